// File: rtl/vec_normalize.sv
// vec_normalize: unit vector u = x / n over four signed Q(W-FRAC).FRAC components, one shared restoring divider.
// Optional macro VEC_NORMALIZE_ROUND_EN selects round-half-away-from-zero instead of truncation.
module vec_normalize #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] x1,
    input  logic [2*W-1:0] x2,
    input  logic [W-1:0]   n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] u1,
    output logic [2*W-1:0] u2,
    output logic           div_zero
);
    localparam int DW = W + FRAC;
    localparam int CW = $clog2(DW);
    localparam logic [DW:0] MAX_POS = {{(DW-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic [DW:0] MAX_NEG = MAX_POS + (DW+1)'(1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t        state, state_next;
    logic [W-1:0]  comp [4];
    logic [W-1:0]  u_r  [4];
    logic [W-1:0]  n_r;
    logic          zero_r;
    logic          neg;
    logic [1:0]    k;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sr;
    logic [W-1:0]  rem;
    logic [W:0]    rem_shift;
    logic          ge;
    logic [W-1:0]  rem_next;
    logic [DW:0]   mag;
    logic [W-1:0]  fix_val;
    logic [W-1:0]  next_comp;

    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = DIV;
            DIV:     if (cnt == CW'(DW-1)) state_next = FIX;
            FIX:     state_next = (k == 2'd3) ? DONE : DIV;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        u1        = {u_r[0], u_r[1]};
        u2        = {u_r[2], u_r[3]};
        div_zero  = zero_r;
    end

    // sr holds the remaining dividend bits on the left and collects quotient bits on the right
    always_comb begin
        rem_shift = {rem, sr[DW-1]};
        ge        = rem_shift >= {1'b0, n_r};
        rem_next  = ge ? W'(rem_shift - {1'b0, n_r}) : rem_shift[W-1:0];
        next_comp = comp[k + 2'd1];
    end

    always_comb begin
`ifdef VEC_NORMALIZE_ROUND_EN
        mag = {1'b0, sr} + (DW+1)'({rem, 1'b0} >= {1'b0, n_r});
`else
        mag = {1'b0, sr};
`endif
        fix_val = '0;
        if (zero_r)
            fix_val = '0;
        else if (neg)
            fix_val = (mag > MAX_NEG) ? {1'b1, {(W-1){1'b0}}} : (~mag[W-1:0] + W'(1));
        else
            fix_val = (mag > MAX_POS) ? {1'b0, {(W-1){1'b1}}} : mag[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                comp[i] <= '0;
                u_r[i]  <= '0;
            end
            n_r    <= '0;
            zero_r <= 1'b0;
            neg    <= 1'b0;
            k      <= '0;
            cnt    <= '0;
            sr     <= '0;
            rem    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        comp[0] <= x1[2*W-1:W];
                        comp[1] <= x1[W-1:0];
                        comp[2] <= x2[2*W-1:W];
                        comp[3] <= x2[W-1:0];
                        n_r     <= n;
                        zero_r  <= (n == '0);
                        k       <= '0;
                        sr      <= {abs_w(x1[2*W-1:W]), {FRAC{1'b0}}};
                        rem     <= '0;
                        cnt     <= '0;
                        neg     <= x1[2*W-1];
                    end
                end
                DIV: begin
                    sr  <= {sr[DW-2:0], ge};
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    u_r[k] <= fix_val;
                    if (k != 2'd3) begin
                        k   <= k + 2'd1;
                        sr  <= {abs_w(next_comp), {FRAC{1'b0}}};
                        rem <= '0;
                        cnt <= '0;
                        neg <= next_comp[W-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/vec_normalize.md
Name: vec_normalize

Overview:
- Downstream neighbour of the 2-D vector norm stage; consumes the complex vector (x1, x2) and its norm n, and produces the unit vector u = x / n for the PCA precoder weights.
- Divides four signed fixed-point components by the unsigned norm using one shared iterative restoring divider.
- Valid/ready handshake on both sides.

Parameters:
- W, 32, width of each signed component and of n.
- FRAC, 16, fractional bits of the Q(W-FRAC).FRAC format used by x, n and u.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  x1, x2 and n valid
- in_ready  out  1  block idle; accepts input on in_valid & in_ready
- x1  in  2W  component 1: {re[2W-1:W], im[W-1:0]}, signed Q16.16 each
- x2  in  2W  component 2: same packing
- n  in  W  unsigned Q16.16 norm
- out_valid  out  1  u1, u2 and div_zero valid
- out_ready  in  1  consumer accepts the result
- u1  out  2W  x1 / n, packed as x1
- u2  out  2W  x2 / n, packed as x2
- div_zero  out  1  n was 0 for the current result

Behaviour:
- Reset (synchronous, with priority over all other inputs): state IDLE; in_ready=1; out_valid=0; u1=u2=0; div_zero=0.
- Reset mid-operation aborts the division; no result is emitted.
- FSM states: IDLE, DIV, FIX, DONE.
- IDLE
  - in_ready=1.
  - On in_valid, latch x1, x2 and n.
  - Component index k = 0 (order: x1.re, x1.im, x2.re, x2.im).
  - Go to DIV; in_ready drops the next cycle.
- DIV
  - Load |component| << FRAC as a (W+FRAC)-bit dividend.
  - Run W+FRAC restoring iterations (one quotient bit per cycle, MSB first).
  - Then go to FIX.
- FIX (one cycle)
  - Apply sign (negate if the component was negative).
  - Saturate to signed W bits: positive overflow gives 0x7FFFFFFF, negative overflow gives 0x80000000.
  - Write the result into the u slot for k.
  - If k<3: k++ and go to DIV. Otherwise go to DONE.
- DONE
  - out_valid=1; u1, u2 and div_zero are held stable while out_ready=0.
  - On out_ready: out_valid=0, go to IDLE (in_ready=1 the following cycle).
- Latency
  - Accept at cycle 0; out_valid rises at cycle 1 + 4*(W+FRAC+1).
  - Default: cycle 197.
  - The latency is fixed for all data, including n=0.
- n==0: the divider still runs, but every quotient is forced to 0 and div_zero=1. Otherwise div_zero=0.
- Rounding: truncation toward zero on the magnitude (default).
- Zero component: result 0. A negated zero stays 0.
- No input is accepted outside IDLE. in_valid is ignored while busy.
- No simultaneous accept and emit: one vector is in flight at a time.

Optional Feature:
- Macro: VEC_NORMALIZE_ROUND_EN.
- Defined: after the last iteration, if 2*remainder >= n, magnitude += 1 (round half away from zero). This is applied before the sign and saturation step; latency is unchanged.
- Undefined: magnitude truncated; no extra logic.

Test Plan:
- x1={0x00030000,0}, x2={0x00040000,0}, n=0x00050000 -> u1.re=0x00009999, u2.re=0x0000CCCC; im=0; div_zero=0; out_valid at cycle 197. With ROUND_EN: 0x0000999A and 0x0000CCCD.
- x1.re=0xFFFD0000 (-3.0), x2.im=0x00040000, n=0x00050000 -> u1.re=0xFFFF6667, u2.im=0x0000CCCC. With ROUND_EN: u1.re=0xFFFF6666, u2.im=0x0000CCCD.
- x1.re=0x7FFF0000, x1.im=0x80010000, n=0x00000100 -> u1.re=0x7FFFFFFF, u1.im=0x80000000 (saturation).
- n=0 with nonzero x -> u1=u2=0, div_zero=1, out_valid at cycle 197.
- out_ready held low 10 cycles after out_valid -> outputs stable, in_ready=0. A new in_valid is ignored until 1 cycle after the out_ready handshake.
- reset asserted at cycle 50 of a division -> next cycle out_valid=0, in_ready=1, u=0. A new vector afterwards gives the correct result at the full latency.
